// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and constants for the register-file writeback arbiter.
//   wb_req_t        : one pending register write {addr, data}
//   WB_* constants  : default widths, buffer depth and derived pointer/count
//                     widths, and the default starvation limit.
// Optional feature macro used by the arbiter: WB_STARVE_GUARD_EN.
package wb_pkg;

  localparam int WB_DATA_W       = 32;
  localparam int WB_ADDR_W       = 5;
  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_PTR_W        = $clog2(WB_FIFO_DEPTH);
  localparam int WB_CNT_W        = WB_PTR_W + 1;
  localparam int WB_STARVE_LIMIT = 8;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Register 0 is hardwired to zero; writes to it are never real writes.
  function automatic logic is_real_reg(input logic [WB_ADDR_W-1:0] addr);
    return addr != {WB_ADDR_W{1'b0}};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- circular buffer for mult/div results awaiting the write port.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enq, enq_addr/data    : push one entry (ignored when full)
//   deq                   : pop the head (ignored when empty)
//   head_addr/data        : current head entry
//   empty, full_next      : status now / full-ness after this cycle's update
//   ent_valid, ent_addr   : per-slot occupancy and destination, for the
//                           pending-destination scoreboard
module wb_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq,
  input  logic [AW-1:0]            enq_addr,
  input  logic [DW-1:0]            enq_data,
  input  logic                     deq,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     empty,
  output logic                     full_next,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][AW-1:0] ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][AW-1:0] addr_mem_r;
  logic [DEPTH-1:0][DW-1:0] data_mem_r;
  logic [DEPTH-1:0]         valid_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_next_s;
  logic                     full_s;
  logic                     enq_ok_s;
  logic                     deq_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign enq_ok_s  = enq && !full_s;
  assign deq_ok_s  = deq && !empty;
  assign full_next = (count_next_s == CNT_W'(DEPTH));
  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];
  assign ent_valid = valid_r;
  assign ent_addr  = addr_mem_r;

  // Occupancy after this cycle; push+pop together leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({enq_ok_s, deq_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and slot-valid flags; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (enq_ok_s) begin
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
        valid_r[wr_ptr_r] <= 1'b1;
      end
      // Push and pop never target the same slot: that needs empty and full at once.
      if (deq_ok_s) begin
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
        valid_r[rd_ptr_r] <= 1'b0;
      end
    end
  end

  // Payload storage; contents are only meaningful where valid_r is set.
  always_ff @(posedge clk) begin
    if (enq_ok_s) begin
      addr_mem_r[wr_ptr_r] <= enq_addr;
      data_mem_r[wr_ptr_r] <= enq_data;
    end
  end

endmodule

// File: rtl/wb_starve_chk.sv
// wb_starve_chk -- checker: upstream must hold pipe_we low while pipe_stall is up.
// Ports: clk, rst_n, pipe_stall, pipe_we (all observed only).
module wb_starve_chk (
  input logic clk,
  input logic rst_n,
  input logic pipe_stall,
  input logic pipe_we
);

  a_no_pipe_during_stall: assert property (
    @(posedge clk) disable iff (!rst_n) !(pipe_stall && pipe_we)
  );

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter -- drives the register file's single write port from the
// never-stalled pipeline writeback and the valid/ready mult/div unit.
// Mult/div results are buffered in wb_fifo; the pipe always has priority.
// Ports:
//   pipe_we/addr/wd       : pipeline writeback request
//   md_valid/ready/addr/wd: mult/div result handshake
//   rf_we/addr/wd         : registered register-file write port
//   q_addr1/2, q_busy1/2  : pending-destination scoreboard queries
//   pipe_stall            : starvation guard request (0 unless enabled)
// Optional feature macro: WB_STARVE_GUARD_EN (starvation counter + pipe_stall).
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int BIT_DEPTH      = WB_DATA_W,
  parameter int LOG_PORT_DEPTH = WB_ADDR_W,
`ifdef WB_STARVE_GUARD_EN
  parameter int STARVE_LIMIT   = WB_STARVE_LIMIT,
`endif
  parameter int FIFO_DEPTH     = WB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_we,
  input  logic [LOG_PORT_DEPTH-1:0] pipe_addr,
  input  logic [BIT_DEPTH-1:0]      pipe_wd,
  input  logic                      md_valid,
  output logic                      md_ready,
  input  logic [LOG_PORT_DEPTH-1:0] md_addr,
  input  logic [BIT_DEPTH-1:0]      md_wd,
  output logic                      rf_we,
  output logic [LOG_PORT_DEPTH-1:0] rf_addr,
  output logic [BIT_DEPTH-1:0]      rf_wd,
  input  logic [LOG_PORT_DEPTH-1:0] q_addr1,
  input  logic [LOG_PORT_DEPTH-1:0] q_addr2,
  output logic                      q_busy1,
  output logic                      q_busy2,
  output logic                      pipe_stall
);

  logic                                     pipe_eff_s;
  logic                                     enq_s;
  logic                                     deq_s;
  logic                                     empty_s;
  logic                                     full_next_s;
  logic [LOG_PORT_DEPTH-1:0]                head_addr_s;
  logic [BIT_DEPTH-1:0]                     head_data_s;
  logic [FIFO_DEPTH-1:0]                    ent_valid_s;
  logic [FIFO_DEPTH-1:0][LOG_PORT_DEPTH-1:0] ent_addr_s;
  logic                                     hit1_s;
  logic                                     hit2_s;
  logic                                     md_ready_r;
  logic                                     rf_we_r;
  wb_req_t                                  issue_r;

  // md_ready is a register so it stays low throughout reset; it equals !full afterwards.
  assign pipe_eff_s = pipe_we && is_real_reg(pipe_addr);
  assign deq_s      = !pipe_eff_s && !empty_s;
  assign enq_s      = md_valid && md_ready_r && is_real_reg(md_addr);

  assign md_ready = md_ready_r;
  assign rf_we    = rf_we_r;
  assign rf_addr  = issue_r.addr;
  assign rf_wd    = issue_r.data;

  wb_fifo #(
    .AW    (LOG_PORT_DEPTH),
    .DW    (BIT_DEPTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq_s),
    .enq_addr  (md_addr),
    .enq_data  (md_wd),
    .deq       (deq_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .empty     (empty_s),
    .full_next (full_next_s),
    .ent_valid (ent_valid_s),
    .ent_addr  (ent_addr_s)
  );

  // Scoreboard: any occupied slot targeting the queried register (head included).
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid_s[i] && (ent_addr_s[i] == q_addr1)) begin
        hit1_s = 1'b1;
      end else begin
        hit1_s = hit1_s;
      end
      if (ent_valid_s[i] && (ent_addr_s[i] == q_addr2)) begin
        hit2_s = 1'b1;
      end else begin
        hit2_s = hit2_s;
      end
    end
  end

  assign q_busy1 = hit1_s && is_real_reg(q_addr1);
  assign q_busy2 = hit2_s && is_real_reg(q_addr2);

  // Issue register: pipe first, else FIFO head; addr/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      issue_r    <= '{addr: {LOG_PORT_DEPTH{1'b0}}, data: {BIT_DEPTH{1'b0}}};
      md_ready_r <= 1'b0;
    end else begin
      rf_we_r    <= pipe_eff_s || deq_s;
      md_ready_r <= !full_next_s;
      if (pipe_eff_s) begin
        issue_r <= '{addr: pipe_addr, data: pipe_wd};
      end else if (deq_s) begin
        issue_r <= '{addr: head_addr_s, data: head_data_s};
      end else begin
        issue_r <= issue_r;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt_r;
  logic [SC_W-1:0] starve_cnt_next_s;
  logic            pipe_stall_r;

  // Blocked-head counter: grows while the head loses to the pipe, clears on any pop.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (deq_s) begin
      starve_cnt_next_s = {SC_W{1'b0}};
    end else if (!empty_s && pipe_eff_s && (starve_cnt_r < SC_W'(STARVE_LIMIT))) begin
      starve_cnt_next_s = starve_cnt_r + SC_W'(1);
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Stall stays up from reaching the limit until the head is finally popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {SC_W{1'b0}};
      pipe_stall_r <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
      pipe_stall_r <= (starve_cnt_next_s == SC_W'(STARVE_LIMIT));
    end
  end

  assign pipe_stall = pipe_stall_r;

  wb_starve_chk u_starve_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_stall (pipe_stall_r),
    .pipe_we    (pipe_we)
  );
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the write-port rules.
module tb_writeback_arbiter;
  import wb_pkg::*;

  localparam int D   = WB_FIFO_DEPTH;
  localparam int LIM = WB_STARVE_LIMIT;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_wd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_wd;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_busy1;
  logic        q_busy2;
  logic        pipe_stall;

  writeback_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wd    (pipe_wd),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_addr    (md_addr),
    .md_wd      (md_wd),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wd      (rf_wd),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .q_busy1    (q_busy1),
    .q_busy2    (q_busy2),
    .pipe_stall (pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: pending mult/div results as a plain queue.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_live = 1'b0;
  bit          e_we   = 1'b0;
  logic [4:0]  e_addr = 5'd0;
  logic [31:0] e_wd   = 32'd0;
  int          m_cnt  = 0;
  bit          e_stall = 1'b0;

  function automatic bit m_busy(input logic [4:0] qa);
    if (qa == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == qa) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    pipe_we = 1'b0; pipe_addr = 5'd0; pipe_wd = 32'd0;
    md_valid = 1'b0; md_addr = 5'd0; md_wd = 32'd0;
    q_addr1 = 5'd0; q_addr2 = 5'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check rf_* after the edge.
  task automatic cycle();
    bit   pipe_eff;
    bit   popped;
    bit   rdy;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_live = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_wd = 32'd0;
      m_cnt = 0; e_stall = 1'b0;
    end
    #1;
    rdy = m_live && rst_n && (mq.size() < D);
    check_eq("md_ready", 32'(md_ready), 32'(rdy));
    check_eq("q_busy1", 32'(q_busy1), 32'(m_busy(q_addr1)));
    check_eq("q_busy2", 32'(q_busy2), 32'(m_busy(q_addr2)));
    check_eq("pipe_stall", 32'(pipe_stall), 32'(e_stall));
    if (rst_n) begin
      pipe_eff = pipe_we && (pipe_addr != 5'd0);
      popped   = 1'b0;
      if (pipe_eff) begin
        e_we = 1'b1; e_addr = pipe_addr; e_wd = pipe_wd;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        e_we = 1'b1; e_addr = e.a; e_wd = e.d; popped = 1'b1;
      end else begin
        e_we = 1'b0;
      end
`ifdef WB_STARVE_GUARD_EN
      if (popped) m_cnt = 0;
      else if (mq.size() > 0 && pipe_eff && m_cnt < LIM) m_cnt++;
      e_stall = !popped && (m_cnt == LIM);
`endif
      if (md_valid && rdy && md_addr != 5'd0) mq.push_back('{md_addr, md_wd});
      m_live = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we || !rst_n) begin
      check_eq("rf_addr", 32'(rf_addr), 32'(e_addr));
      check_eq("rf_wd", rf_wd, e_wd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();

    // 1: reset state and release
    q_addr1 = 5'd7;
    cycle(); cycle();
    check_eq("rst_md_ready", 32'(md_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    check_eq("rel_md_ready", 32'(md_ready), 32'd1);

    // 2: pipeline write, one-cycle pulse
    pipe_we = 1'b1; pipe_addr = 5'd5; pipe_wd = 32'hDEADBEEF;
    cycle();
    check_eq("t2_addr", 32'(rf_addr), 32'd5);
    check_eq("t2_wd", rf_wd, 32'hDEADBEEF);
    set_idle();
    cycle();
    check_eq("t2_pulse", 32'(rf_we), 32'd0);

    // 3: mult/div write with idle pipe
    md_valid = 1'b1; md_addr = 5'd7; md_wd = 32'h12345678; q_addr1 = 5'd7;
    cycle();
    md_valid = 1'b0;
    check_eq("t3_busy", 32'(q_busy1), 32'd1);
    cycle();
    check_eq("t3_addr", 32'(rf_addr), 32'd7);
    check_eq("t3_wd", rf_wd, 32'h12345678);
    check_eq("t3_busy_clr", 32'(q_busy1), 32'd0);
    cycle();

    // 4: fill while pipe holds the port, then drain in order
    pipe_we = 1'b1; pipe_addr = 5'd20;
    for (int k = 1; k <= 4; k++) begin
      pipe_wd = $urandom; md_valid = 1'b1; md_addr = 5'(k); md_wd = 32'h111 * k;
      cycle();
    end
    md_valid = 1'b0;
    check_eq("t4_full", 32'(md_ready), 32'd0);
    pipe_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check_eq("t4_order", 32'(rf_addr), 32'(k));
      if (k == 1) check_eq("t4_ready_back", 32'(md_ready), 32'd1);
    end

    // mid-operation reset discards queued entries
    pipe_we = 1'b1; pipe_addr = 5'd6; md_valid = 1'b1; md_addr = 5'd12; q_addr2 = 5'd12;
    cycle(); cycle();
    set_idle(); q_addr2 = 5'd12;
    rst_n = 1'b0;
    cycle();
    check_eq("mid_rst_busy", 32'(q_busy2), 32'd0);
    rst_n = 1'b1;
    cycle(); cycle();
    check_eq("mid_rst_nowr", 32'(rf_we), 32'd0);

    // 5: register 0 handling
    pipe_we = 1'b1; pipe_addr = 5'd3; md_valid = 1'b1; md_addr = 5'd9; md_wd = 32'hA5A5_0009;
    cycle();
    md_valid = 1'b0; pipe_addr = 5'd0;
    cycle();
    check_eq("t5_head", 32'(rf_addr), 32'd9);
    set_idle();
    md_valid = 1'b1; md_addr = 5'd0; md_wd = 32'hFFFF_FFFF;
    cycle();
    md_valid = 1'b0;
    cycle();
    check_eq("t5_r0_nowr", 32'(rf_we), 32'd0);

`ifdef WB_STARVE_GUARD_EN
    // 6: starvation guard
    pipe_we = 1'b1; pipe_addr = 5'd2; md_valid = 1'b1; md_addr = 5'd10; md_wd = 32'h0BAD_F00D;
    cycle();
    md_valid = 1'b0;
    for (int i = 0; i < LIM; i++) cycle();
    check_eq("t6_stall", 32'(pipe_stall), 32'd1);
    pipe_we = 1'b0;
    cycle();
    check_eq("t6_head", 32'(rf_addr), 32'd10);
    check_eq("t6_unstall", 32'(pipe_stall), 32'd0);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      pipe_we   = ($urandom_range(0, 9) < 4);
      pipe_addr = 5'($urandom_range(0, 7));
      pipe_wd   = $urandom;
      md_valid  = ($urandom_range(0, 9) < 6);
      md_addr   = 5'($urandom_range(0, 7));
      md_wd     = $urandom;
      q_addr1   = 5'($urandom_range(0, 7));
      q_addr2   = 5'($urandom_range(0, 31));
      if (pipe_stall) pipe_we = 1'b0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
